telem_rx: RTL and testbench
===========================

# telem_rx

Telemetry receiver: the far end of the eBike `TX` serial link. It deserializes 8N1 UART bytes and frame-syncs on a two-byte header. It checks each payload frame and presents the reconstructed 12-bit `batt`, `curr` and `torque` readings with a single-cycle valid strobe. It sits on the bench/display side of the link and is also used as the self-check monitor in full-chip eBike testbenches.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud); legal range ≥ 8.
- `TMO_BITS`, default 32: inter-byte timeout, in bit-times, while mid-frame.
- `clk` input 1: 50 MHz system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `RX` input 1: serial line, idle high, asynchronous to `clk`.
- `batt` output 12: last good battery reading.
- `curr` output 12: last good current reading.
- `torque` output 12: last good torque reading.
- `vld` output 1: one-cycle pulse when `batt`/`curr`/`torque` update.
- `err` output 1: one-cycle pulse on a dropped frame or byte.

## Operation
- Frame format, 8 bytes, each 8N1 LSB first: `0xAA`, `0x55`, `{4'h0,batt[11:8]}`, `batt[7:0]`, `{4'h0,curr[11:8]}`, `curr[7:0]`, `{4'h0,torque[11:8]}`, `torque[7:0]`.
- `RX` is double-flopped; both flops reset to 1.
- **Byte receiver**
  - A falling edge of the synchronized `RX` starts a byte.
  - The start bit is re-sampled at `BAUD_DIV/2`. If it is high, the edge was a glitch: return to idle with no error.
  - The 8 data bits and the stop bit are sampled at mid-bit, every `BAUD_DIV` clocks.
  - Stop bit = 1: `rdy` pulses for one cycle with `rx_data`.
  - Stop bit = 0: `ferr` pulses and no `rdy` is produced.
  - The receiver rearms immediately after the stop sample. Back-to-back bytes with no idle time must be received.
- **Frame FSM states: IDLE, HDR2, PAY.**
  - IDLE: `0xAA` goes to HDR2. Any other byte stays in IDLE.
  - HDR2: `0x55` goes to PAY with `cnt=0`. `0xAA` stays in HDR2. Any other byte goes to IDLE.
  - PAY: each `rdy` stores the byte into `shadow[cnt]`, then `cnt++`.
  - When `cnt` is 0, 2 or 4 (high bytes), bits [7:4] must be 0. A violation gives `err` and IDLE.
  - On `cnt==5` `rdy`: commit all three outputs from the shadow registers in the same edge, pulse `vld`, and go to IDLE.
  - `ferr` in HDR2 or PAY gives `err` and IDLE. `ferr` in IDLE gives `err` only.
  - Timeout: in HDR2 or PAY, a counter counts clocks since the last `rdy`. When it reaches `TMO_BITS*BAUD_DIV`, pulse `err` and go to IDLE. The counter is cleared on each `rdy` and held at 0 in IDLE.
- Outputs hold their last committed values. A partial or dropped frame never changes `batt`/`curr`/`torque`.
- Arithmetic is unsigned only. The baud counter is `$clog2(BAUD_DIV)` bits wide and the timeout counter is `$clog2(TMO_BITS*BAUD_DIV+1)` bits wide.

## Timing
- Reset values:
  - `batt`, `curr`, `torque` = 0.
  - `vld` = 0 and `err` = 0.
  - FSM in IDLE, receiver idle, `cnt` = 0, shadow registers = 0.
- Reset asserted mid-frame aborts immediately with no `vld` and no `err`. After release, the FSM must see a fresh `0xAA`.
- Sampling latency: from an `RX` edge at the pin to the synchronized edge is 2 clocks.
- Byte latency: `rdy` asserts on the clock after the stop-bit sample, i.e. about 9.5 bit-times + 3 clocks after the start edge.
- `vld`/`err` registration: both are registered and assert 1 clock after the causing `rdy`/`ferr`/timeout. Committed outputs become visible in the same cycle as `vld`.
- `vld` and `err` are never asserted in the same cycle.
- Both are exactly 1 cycle wide and are never stretched.
- A header for the next frame may start the cycle after the final stop bit and must not be missed.

## Structure
- Shared package `telem_pkg`:
  - constants `HDR0=8'hAA`, `HDR1=8'h55`, `PAY_BYTES=6`.
  - the typedef `enum logic [1:0] {IDLE,HDR2,PAY} telem_state_t`.
  - The eBike transmitter imports the same package so that framing stays in one place.
- One sub-module, `uart_rx_byte` (params `BAUD_DIV`; ports `clk`, `rst_n`, `RX`, `rx_data[7:0]`, `rdy`, `ferr`). It contains the synchronizer, the baud counter and the shift register.
- `telem_rx` contains the frame FSM, payload counter, shadow registers, timeout counter and output registers.

## Test plan
Simulate with `BAUD_DIV=16` and `TMO_BITS=32`.
- **Good frame:** send AA 55 0A BC 03 21 0F FF → one `vld`; `batt=12'hABC`, `curr=12'h321`, `torque=12'hFFF`; no `err`.
- **Resync:** send 13 AA AA 55 01 00 02 00 03 00 → `vld` with `batt=12'h100`, `curr=12'h200`, `torque=12'h300`.
- **Bad high nibble:** send AA 55 1A BC … → `err` 1 clock after the 3rd payload-start byte; outputs unchanged; a following good frame produces `vld`.
- **Stop-bit violation:** drive stop=0 on the 5th byte → one `err`, no `vld`, outputs hold. The next frame is decoded.
- **Timeout:** send AA 55 05, then idle for 33 bit-times → `err` at 32×16 clocks after that byte's `rdy`. A later full frame decodes.
- **Reset mid-frame, and back-to-back frames:**
  - Assert `rst_n` low after byte 4 → all outputs 0, no pulses.
  - Then send two frames with zero idle between them → two `vld` pulses, values match each frame.
  - A 3-clock low glitch on `RX` produces no byte.

Source files
------------

// File: rtl/telem_pkg.sv
// Framing constants and state types shared by the telemetry receiver and the
// eBike transmitter, so the frame layout is defined in exactly one place.
package telem_pkg;

    localparam logic [7:0] HDR0      = 8'hAA;
    localparam logic [7:0] HDR1      = 8'h55;
    localparam int         PAY_BYTES = 6;

    typedef enum logic [1:0] {IDLE, HDR2, PAY} telem_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: double-flop synchronizer, mid-bit sampling baud counter
// and LSB-first shift register.
module uart_rx_byte
    import telem_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       ferr
);

    localparam int            CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt, data_nxt;
    logic          rdy_nxt, ferr_nxt;

    // rx_prev only feeds the falling-edge detector; it is not a third sync stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            rx_data  <= data_nxt;
            rdy      <= rdy_nxt;
            ferr     <= ferr_nxt;
        end
    end

    // rdy and ferr are single-cycle strobes with no back-pressure; rx_data is
    // meaningful while rdy is high and holds until the next good byte.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        data_nxt     = rx_data;
        rdy_nxt      = 1'b0;
        ferr_nxt     = 1'b0;
        case (state)
            RX_IDLE: begin
                baud_cnt_nxt = '0;
                if (rx_prev && !rx_sync) state_nxt = RX_START;
            end
            RX_START: begin
                if (baud_cnt == HALF_M1) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    state_nxt    = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_nxt = '0;
                    shift_nxt    = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = RX_IDLE;
                    if (rx_sync) begin
                        rdy_nxt  = 1'b1;
                        data_nxt = shift;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/telem_rx.sv
// Telemetry receiver: frame-syncs on AA 55, validates the six payload bytes and
// commits batt/curr/torque together with a one-cycle vld strobe.
module telem_rx
    import telem_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int TMO_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        err
);

    localparam int            TW      = $clog2(TMO_BITS * BAUD_DIV + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TMO_BITS * BAUD_DIV);
    localparam logic [2:0]    LAST    = 3'(PAY_BYTES - 1);

    logic [7:0]    rx_data;
    logic          rdy, ferr;

    telem_state_t  state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [7:0]    shadow [PAY_BYTES];
    logic          shadow_we, commit, vld_nxt, err_nxt;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_data (rx_data),
        .rdy     (rdy),
        .ferr    (ferr)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shadow_we = 1'b0;
        commit    = 1'b0;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (ferr) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
        end else if (rdy) begin
            case (state)
                IDLE: if (rx_data == HDR0) state_nxt = HDR2;
                HDR2: begin
                    if (rx_data == HDR1) begin
                        state_nxt = PAY;
                        cnt_nxt   = '0;
                    end else if (rx_data != HDR0) begin
                        state_nxt = IDLE;
                    end
                end
                PAY: begin
                    // Even slots carry the upper nibble of a 12-bit reading.
                    if (!cnt[0] && rx_data[7:4] != 4'h0) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        shadow_we = 1'b1;
                        if (cnt == LAST) begin
                            commit    = 1'b1;
                            vld_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt + 3'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_LIM) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
        end
        if (state_nxt == IDLE) cnt_nxt = '0;
        tmo_nxt = (state_nxt == IDLE || rdy) ? '0 : tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tmo_cnt <= '0;
            vld     <= 1'b0;
            err     <= 1'b0;
            batt    <= '0;
            curr    <= '0;
            torque  <= '0;
            for (int i = 0; i < PAY_BYTES; i++) shadow[i] <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tmo_cnt <= tmo_nxt;
            vld     <= vld_nxt;
            err     <= err_nxt;
            if (shadow_we) shadow[cnt] <= rx_data;
            // The final low byte is taken straight from rx_data so all three
            // readings change on the same edge as the last shadow write.
            if (commit) begin
                batt   <= {shadow[0][3:0], shadow[1]};
                curr   <= {shadow[2][3:0], shadow[3]};
                torque <= {shadow[4][3:0], rx_data};
            end
        end
    end

endmodule

// File: tb/tb_telem_rx.sv
// Bench for telem_rx: table-driven frames, hand-written corner sequences and a
// randomized byte stream checked against a queue-based frame parser model.
module tb_telem_rx;
    import telem_pkg::*;

    localparam int BD = 16;
    localparam int TB = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        vld, err;

    telem_rx #(.BAUD_DIV(BD), .TMO_BITS(TB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (rx),
        .batt   (batt),
        .curr   (curr),
        .torque (torque),
        .vld    (vld),
        .err    (err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   vld_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   last_err_cyc = 0;
    logic vld_d = 1'b0;
    logic err_d = 1'b0;
    logic [35:0] exp_q[$];
    logic [35:0] e_pop;

    // Reference model: byte-stream parser over a payload queue.
    logic [7:0]  m_prev = 8'h00;
    bit          m_in = 1'b0;
    logic [7:0]  m_pay[$];
    logic [35:0] m_out = '0;
    int          m_err = 0;
    int          m_vld = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (vld) begin
                vld_cnt++;
                check("vld_err_excl", {63'b0, err}, 64'd0);
                check("vld_width", {63'b0, vld_d}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("vld_unexpected", 64'd1, 64'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("vld_data", {28'b0, batt, curr, torque}, {28'b0, e_pop});
                end
            end
            if (err) begin
                err_cnt++;
                last_err_cyc = cyc;
                check("err_width", {63'b0, err_d}, 64'd0);
            end
        end
        vld_d = vld;
        err_d = err;
    end

    task automatic model_byte(input logic [7:0] b);
        if (m_in) begin
            if ((m_pay.size() % 2) == 0 && b[7:4] != 4'h0) begin
                m_err++;
                m_in = 1'b0;
                m_prev = 8'h00;
            end else begin
                m_pay.push_back(b);
                if (m_pay.size() == 6) begin
                    m_out = {m_pay[0][3:0], m_pay[1], m_pay[2][3:0], m_pay[3], m_pay[4][3:0], m_pay[5]};
                    exp_q.push_back(m_out);
                    m_vld++;
                    m_in = 1'b0;
                    m_prev = 8'h00;
                end
            end
        end else begin
            if (m_prev == HDR0 && b == HDR1) begin
                m_in = 1'b1;
                m_pay.delete();
            end
            m_prev = b;
        end
    endtask

    task automatic model_ferr();
        m_err++;
        m_in = 1'b0;
        m_prev = 8'h00;
    endtask

    task automatic model_idle_timeout();
        if (m_in || m_prev == HDR0) m_err++;
        m_in = 1'b0;
        m_prev = 8'h00;
    endtask

    task automatic model_reset();
        m_in = 1'b0;
        m_prev = 8'h00;
        m_out = '0;
        m_pay.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (BD) @(negedge clk);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b, 1'b1);
    endtask

    task automatic send_bad(input logic [7:0] b);
        model_ferr();
        send_raw(b, 1'b0);
        idle(BD);
    endtask

    task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte({4'h0, b[11:8]});
        send_byte(b[7:0]);
        send_byte({4'h0, c[11:8]});
        send_byte(c[7:0]);
        send_byte({4'h0, t[11:8]});
        send_byte(t[7:0]);
    endtask

    typedef struct {
        logic [63:0] bytes;
        logic        exp_vld;
        logic [11:0] eb;
        logic [11:0] ec;
        logic [11:0] et;
        int          exp_err;
    } vec_t;

    initial begin
        vec_t        tbl [7];
        logic [7:0]  rs [10];
        logic [63:0] fb;
        int          v0;
        int          e0;
        int          s;
        int          kind;
        int          n;

        tbl[0] = '{64'hAA550ABC03210FFF, 1'b1, 12'hABC, 12'h321, 12'hFFF, 0};
        tbl[1] = '{64'hAA551ABC03210FFF, 1'b0, 12'hABC, 12'h321, 12'hFFF, 1};
        tbl[2] = '{64'hAA55010203040506, 1'b1, 12'h102, 12'h304, 12'h506, 0};
        tbl[3] = '{64'hAA55055A000001FF, 1'b1, 12'h55A, 12'h000, 12'h1FF, 0};
        tbl[4] = '{64'hAA5500000000F000, 1'b0, 12'h55A, 12'h000, 12'h1FF, 1};
        tbl[5] = '{64'hAA550FFF0FFF0FFF, 1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 0};
        tbl[6] = '{64'hAA55000000000000, 1'b1, 12'h000, 12'h000, 12'h000, 0};
        rs = '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};

        // Reset
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_outputs", {28'b0, batt, curr, torque}, 64'd0);
        check("rst_pulses", {62'b0, vld, err}, 64'd0);
        rst_n = 1'b1;
        idle(4);
        check("post_rst_outputs", {28'b0, batt, curr, torque}, 64'd0);
        check("post_rst_pulses", {62'b0, vld, err}, 64'd0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            v0 = vld_cnt;
            e0 = err_cnt;
            fb = tbl[i].bytes;
            for (int k = 0; k < 8; k++) send_byte(fb[63 - 8 * k -: 8]);
            idle(2 * BD);
            check("tbl_vld", 64'(vld_cnt - v0), 64'(tbl[i].exp_vld));
            check("tbl_err", 64'(err_cnt - e0), 64'(tbl[i].exp_err));
            check("tbl_out", {28'b0, batt, curr, torque}, {28'b0, tbl[i].eb, tbl[i].ec, tbl[i].et});
        end

        // Resync through garbage and a repeated header byte
        v0 = vld_cnt;
        for (int k = 0; k < 10; k++) send_byte(rs[k]);
        idle(2 * BD);
        check("resync_vld", 64'(vld_cnt - v0), 64'd1);
        check("resync_out", {28'b0, batt, curr, torque}, {28'b0, 12'h100, 12'h200, 12'h300});

        // Bad high nibble: err timing relative to the offending byte
        e0 = err_cnt;
        send_byte(HDR0);
        send_byte(HDR1);
        s = cyc;
        send_byte(8'h1A);
        check("nibble_err", 64'(err_cnt - e0), 64'd1);
        check("nibble_err_time", 64'((last_err_cyc >= s + 154) && (last_err_cyc <= s + 159)), 64'd1);
        send_byte(8'hBC);
        idle(2 * BD);
        check("nibble_hold", {28'b0, batt, curr, torque}, {28'b0, 12'h100, 12'h200, 12'h300});
        send_frame(12'h456, 12'h789, 12'h0AB);
        idle(2 * BD);
        check("nibble_recover", {28'b0, batt, curr, torque}, {28'b0, 12'h456, 12'h789, 12'h0AB});

        // Stop-bit violation on the 5th byte
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte(8'h0A);
        send_byte(8'hBC);
        send_bad(8'h03);
        idle(2 * BD);
        check("ferr_err", 64'(err_cnt - e0), 64'd1);
        check("ferr_no_vld", 64'(vld_cnt - v0), 64'd0);
        check("ferr_hold", {28'b0, batt, curr, torque}, {28'b0, 12'h456, 12'h789, 12'h0AB});
        send_frame(12'h777, 12'h888, 12'h999);
        idle(2 * BD);
        check("ferr_recover", {28'b0, batt, curr, torque}, {28'b0, 12'h777, 12'h888, 12'h999});

        // Inter-byte timeout mid-frame
        e0 = err_cnt;
        send_byte(HDR0);
        send_byte(HDR1);
        s = cyc;
        send_byte(8'h05);
        idle(33 * BD);
        model_idle_timeout();
        check("tmo_err", 64'(err_cnt - e0), 64'd1);
        check("tmo_err_time", 64'((last_err_cyc >= s + 666) && (last_err_cyc <= s + 672)), 64'd1);
        check("tmo_hold", {28'b0, batt, curr, torque}, {28'b0, 12'h777, 12'h888, 12'h999});
        send_frame(12'h321, 12'h654, 12'h987);
        idle(2 * BD);
        check("tmo_recover", {28'b0, batt, curr, torque}, {28'b0, 12'h321, 12'h654, 12'h987});

        // Reset mid-frame, then a headerless tail and back-to-back frames
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte(8'h01);
        send_byte(8'h23);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst_outputs", {28'b0, batt, curr, torque}, 64'd0);
        check("midrst_pulses", {62'b0, vld, err}, 64'd0);
        rst_n = 1'b1;
        idle(4);
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h00);
        idle(2 * BD);
        check("midrst_no_vld", 64'(vld_cnt - v0), 64'd0);
        check("midrst_out_zero", {28'b0, batt, curr, torque}, 64'd0);
        send_frame(12'h123, 12'h456, 12'h789);
        send_frame(12'hABC, 12'hDEF, 12'h111);
        idle(2 * BD);
        check("b2b_vld", 64'(vld_cnt - v0), 64'd2);
        check("b2b_err", 64'(err_cnt - e0), 64'd0);
        check("b2b_out", {28'b0, batt, curr, torque}, {28'b0, 12'hABC, 12'hDEF, 12'h111});

        // Short low glitch while waiting for the second header byte
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(HDR0);
        idle(2 * BD);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(12 * BD);
        send_byte(HDR1);
        send_byte(8'h0C);
        send_byte(8'h01);
        send_byte(8'h0D);
        send_byte(8'h02);
        send_byte(8'h0E);
        send_byte(8'h03);
        idle(2 * BD);
        check("glitch_vld", 64'(vld_cnt - v0), 64'd1);
        check("glitch_err", 64'(err_cnt - e0), 64'd0);
        check("glitch_out", {28'b0, batt, curr, torque}, {28'b0, 12'hC01, 12'hD02, 12'hE03});

        // Randomized stream against the model
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1: send_frame(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                                 12'($urandom_range(0, 4095)));
                2: send_byte(8'($urandom_range(0, 255)));
                3: begin
                    send_byte(HDR0);
                    send_byte(HDR1);
                    n = $urandom_range(0, 5);
                    for (int j = 0; j < n; j++) begin
                        if ((j % 2) == 0 && $urandom_range(0, 3) != 0)
                            send_byte(8'($urandom_range(0, 15)));
                        else
                            send_byte(8'($urandom_range(0, 255)));
                    end
                end
                default: send_bad(8'($urandom_range(0, 255)));
            endcase
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 40));
        end
        idle(34 * BD);
        model_idle_timeout();
        idle(4);

        check("total_vld", 64'(vld_cnt), 64'(m_vld));
        check("total_err", 64'(err_cnt), 64'(m_err));
        check("final_out", {28'b0, batt, curr, torque}, {28'b0, m_out});
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
